// File: rtl/rv_test_pkg.sv
// Shared types and constants for the rv32is batch test sequencer.
package rv_test_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCpuRst,
    StRun,
    StCheck,
    StNext,
    StDone
  } seq_state_e;

  // Per-test verdict codes reported on result_code.
  localparam logic [1:0] RES_PASS = 2'b00;
  localparam logic [1:0] RES_FAIL = 2'b01;
  localparam logic [1:0] RES_UNK  = 2'b10;
  localparam logic [1:0] RES_TMO  = 2'b11;

  // Default handshake words agreed with the riscv-tests images.
  localparam logic [31:0] DEF_HALT_INSTR = 32'hdead10cc;
  localparam logic [31:0] DEF_PASS_MAGIC = 32'h00c0ffee;
  localparam logic [31:0] DEF_FAIL_MAGIC = 32'hdeaddead;

endpackage

// File: rtl/test_verdict.sv
// Classifies the a0 magic value and keeps the aggregate pass/fail tallies.
module test_verdict
  import rv_test_pkg::*;
#(
  parameter int unsigned NUM_TESTS  = 38,
  parameter int unsigned SEL_W      = 6,
  parameter logic [31:0] PASS_MAGIC = DEF_PASS_MAGIC,
  parameter logic [31:0] FAIL_MAGIC = DEF_FAIL_MAGIC
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          a0,
  output logic [1:0]           a0_code,
  input  logic                 clear,
  input  logic                 update,
  input  logic [1:0]           code,
  input  logic [SEL_W-1:0]     sel,
  output logic [SEL_W:0]       pass_count,
  output logic [SEL_W:0]       fail_count,
  output logic [NUM_TESTS-1:0] pass_mask
);

  localparam logic [NUM_TESTS-1:0] MaskOne = NUM_TESTS'(1);
  localparam logic [SEL_W:0]       CntOne  = (SEL_W + 1)'(1);

  logic [SEL_W:0]       pass_count_q, pass_count_d;
  logic [SEL_W:0]       fail_count_q, fail_count_d;
  logic [NUM_TESTS-1:0] pass_mask_q, pass_mask_d;

  // Map the a0 magic value onto a verdict code.
  always_comb begin
    a0_code = RES_UNK;
    if (a0 == PASS_MAGIC) begin
      a0_code = RES_PASS;
    end else if (a0 == FAIL_MAGIC) begin
      a0_code = RES_FAIL;
    end
  end

  // Clear at batch start, otherwise fold one finished test into the tallies.
  always_comb begin
    pass_count_d = pass_count_q;
    fail_count_d = fail_count_q;
    pass_mask_d  = pass_mask_q;
    if (clear) begin
      pass_count_d = '0;
      fail_count_d = '0;
      pass_mask_d  = '0;
    end else if (update) begin
      if (code == RES_PASS) begin
        pass_count_d = pass_count_q + CntOne;
        pass_mask_d  = pass_mask_q | (MaskOne << sel);
      end else begin
        fail_count_d = fail_count_q + CntOne;
      end
    end
  end

  // Tally registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_count_q <= '0;
      fail_count_q <= '0;
      pass_mask_q  <= '0;
    end else begin
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
      pass_mask_q  <= pass_mask_d;
    end
  end

  assign pass_count = pass_count_q;
  assign fail_count = fail_count_q;
  assign pass_mask  = pass_mask_q;

endmodule

// File: rtl/cpu_test_sequencer.sv
// Batch controller: load each test image, reset and run the CPU, record the verdict.
module cpu_test_sequencer
  import rv_test_pkg::*;
#(
  parameter int unsigned NUM_TESTS    = 38,
  parameter int unsigned SEL_W        = 6,
  parameter int unsigned CYC_W        = 16,
  parameter int unsigned MAX_CYCLES   = 10000,
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] HALT_INSTR   = DEF_HALT_INSTR,
  parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC,
  parameter logic [31:0] FAIL_MAGIC   = DEF_FAIL_MAGIC
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 load_req,
  input  logic                 load_done,
  output logic [SEL_W-1:0]     test_sel,
  output logic                 cpu_reset,
  input  logic [31:0]          cpu_instr,
  input  logic [31:0]          cpu_a0,
  output logic                 busy,
  output logic                 done,
  output logic [CYC_W-1:0]     cur_cycles,
  output logic                 result_valid,
  output logic [1:0]           result_code,
  output logic [SEL_W:0]       pass_count,
  output logic [SEL_W:0]       fail_count,
  output logic [NUM_TESTS-1:0] pass_mask
);

  localparam int unsigned      RC_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [RC_W-1:0]  RstLast = RC_W'(RESET_CYCLES - 1);
  localparam logic [CYC_W-1:0] CycLast = CYC_W'(MAX_CYCLES - 1);
  localparam logic [SEL_W-1:0] SelLast = SEL_W'(NUM_TESTS - 1);

  seq_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [1:0]       code_q, code_d;
  logic [1:0]       a0_code;
  logic             busy_s;
  logic             clear_s;

  assign busy_s = (state_q == StLoad) || (state_q == StCpuRst) || (state_q == StRun) ||
                  (state_q == StCheck) || (state_q == StNext);

  // Next-state logic; abort out of any busy state wins over everything else.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    rcnt_d  = rcnt_q;
    code_d  = code_q;
    clear_s = 1'b0;
    if (busy_s && abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StLoad;
            sel_d   = '0;
            clear_s = 1'b1;
          end
        end
        StLoad: begin
          if (load_done) begin
            state_d = StCpuRst;
            rcnt_d  = '0;
          end
        end
        StCpuRst: begin
          if (rcnt_q == RstLast) begin
            state_d = StRun;
            cyc_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RC_W'(1);
          end
        end
        StRun: begin
          // Halt beats timeout when both land in the same cycle.
          if (cpu_instr == HALT_INSTR) begin
            state_d = StCheck;
          end else if (cyc_q == CycLast) begin
            code_d  = RES_TMO;
            state_d = StNext;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        StCheck: begin
          code_d  = a0_code;
          state_d = StNext;
        end
        StNext: begin
          if (sel_q == SelLast) begin
            state_d = StDone;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = StLoad;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cyc_q   <= '0;
      rcnt_q  <= '0;
      code_q  <= RES_PASS;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      rcnt_q  <= rcnt_d;
      code_q  <= code_d;
    end
  end

  test_verdict #(
    .NUM_TESTS (NUM_TESTS),
    .SEL_W     (SEL_W),
    .PASS_MAGIC(PASS_MAGIC),
    .FAIL_MAGIC(FAIL_MAGIC)
  ) u_verdict (
    .clock     (clock),
    .reset     (reset),
    .a0        (cpu_a0),
    .a0_code   (a0_code),
    .clear     (clear_s),
    .update    (state_q == StNext),
    .code      (code_q),
    .sel       (sel_q),
    .pass_count(pass_count),
    .fail_count(fail_count),
    .pass_mask (pass_mask)
  );

  // Outputs are pure functions of state so async reset takes effect at once.
  assign load_req     = (state_q == StLoad);
  assign cpu_reset    = (state_q != StRun);
  assign busy         = busy_s;
  assign done         = (state_q == StDone);
  assign result_valid = (state_q == StNext);
  assign result_code  = code_q;
  assign test_sel     = sel_q;
  assign cur_cycles   = cyc_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Directed bench: three-test batches covering pass, mixed, timeout, collision, abort, reset.
module tb_cpu_test_sequencer;
  import rv_test_pkg::*;

  localparam int unsigned NT    = 3;
  localparam int unsigned SW    = 2;
  localparam int unsigned CW    = 16;
  localparam int unsigned MAXC  = 20;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] UNK   = 32'h12345678;

  logic          clock, reset, start, abort, load_req, load_done, cpu_reset;
  logic [SW-1:0] test_sel;
  logic [31:0]   cpu_instr, cpu_a0;
  logic          busy, done, result_valid;
  logic [CW-1:0] cur_cycles;
  logic [1:0]    result_code;
  logic [SW:0]   pass_count, fail_count;
  logic [NT-1:0] pass_mask;

  int vectors = 0;
  int errors  = 0;

  cpu_test_sequencer #(
    .NUM_TESTS   (NT),
    .SEL_W       (SW),
    .CYC_W       (CW),
    .MAX_CYCLES  (MAXC),
    .RESET_CYCLES(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .load_req    (load_req),
    .load_done   (load_done),
    .test_sel    (test_sel),
    .cpu_reset   (cpu_reset),
    .cpu_instr   (cpu_instr),
    .cpu_a0      (cpu_a0),
    .busy        (busy),
    .done        (done),
    .cur_cycles  (cur_cycles),
    .result_valid(result_valid),
    .result_code (result_code),
    .pass_count  (pass_count),
    .fail_count  (fail_count),
    .pass_mask   (pass_mask)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From LOAD: ack after 3 cycles of load_req, then sit out the 2-cycle CPU reset.
  task automatic enter_run();
    check("load_req_high", load_req, 1'b1);
    repeat (2) tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("load_req_dropped", load_req, 1'b0);
    check("cpu_reset_in_rst", cpu_reset, 1'b1);
    repeat (2) tick();
    check("cpu_reset_released", cpu_reset, 1'b0);
    check("run_start_cycles", cur_cycles, 0);
  endtask

  // Run until result_valid; halt word appears when cur_cycles == halt_at (-1: never).
  task automatic finish_test(input int halt_at, input logic [31:0] a0,
                             input logic [1:0] exp_code, input int exp_cyc);
    int n = 0;
    cpu_a0 = a0;
    while (!result_valid && n < 100) begin
      cpu_instr = (!cpu_reset && halt_at >= 0 && int'(cur_cycles) == halt_at) ? DEF_HALT_INSTR
                                                                                : NOP;
      tick();
      n++;
    end
    cpu_instr = NOP;
    check("result_within_bound", n < 100, 1'b1);
    check("result_code", result_code, exp_code);
    check("cycles_at_result", cur_cycles, exp_cyc);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    load_done = 1'b0;
    cpu_instr = NOP;
    cpu_a0    = '0;
    #2 reset  = 1'b0;
    repeat (2) tick();

    // Reset state.
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_load_req", load_req, 1'b0);
    check("rst_test_sel", test_sel, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cycles", cur_cycles, 0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_code", result_code, 2'b00);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    check("rst_mask", pass_mask, 0);
    reset = 1'b1;
    tick();

    // Batch A: every test halts at cycle 5 with the pass magic.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("a_test_sel", test_sel, i);
      enter_run();
      finish_test(5, DEF_PASS_MAGIC, RES_PASS, 5);
      tick();
    end
    check("a_done", done, 1'b1);
    check("a_busy_off", busy, 1'b0);
    check("a_cpu_reset", cpu_reset, 1'b1);
    check("a_pass", pass_count, 3);
    check("a_fail", fail_count, 0);
    check("a_mask", pass_mask, 3'b111);

    // Batch B: pass, fail on the timeout cycle (halt wins), unknown.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b_cleared_pass", pass_count, 0);
    check("b_cleared_mask", pass_mask, 0);
    check("b_done_cleared", done, 1'b0);
    enter_run();
    finish_test(2, DEF_PASS_MAGIC, RES_PASS, 2);
    tick();
    enter_run();
    finish_test(19, DEF_FAIL_MAGIC, RES_FAIL, 19);
    tick();
    enter_run();
    finish_test(4, UNK, RES_UNK, 4);
    tick();
    check("b_done", done, 1'b1);
    check("b_pass", pass_count, 1);
    check("b_fail", fail_count, 2);
    check("b_mask", pass_mask, 3'b001);

    // Batch C: timeout, then start ignored and abort during test 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    enter_run();
    finish_test(-1, DEF_PASS_MAGIC, RES_TMO, 19);
    tick();
    check("c_tmo_fail", fail_count, 1);
    check("c_next_load", load_req, 1'b1);
    check("c_next_sel", test_sel, 1);
    enter_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c_start_ignored_run", cpu_reset, 1'b0);
    check("c_start_ignored_cyc", cur_cycles, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("c_abort_busy", busy, 1'b0);
    check("c_abort_cpu_reset", cpu_reset, 1'b1);
    check("c_abort_done", done, 1'b0);
    check("c_abort_load_req", load_req, 1'b0);
    check("c_abort_fail_kept", fail_count, 1);
    check("c_abort_pass_kept", pass_count, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c_restart_clear", fail_count, 0);
    check("c_restart_sel", test_sel, 0);
    enter_run();
    finish_test(1, DEF_PASS_MAGIC, RES_PASS, 1);
    tick();
    check("c_load_sel1", test_sel, 1);
    check("c_pass_before_rst", pass_count, 1);

    // Async reset mid-LOAD, asserted between edges.
    #3 reset = 1'b0;
    #1;
    check("ar_load_req", load_req, 1'b0);
    check("ar_cpu_reset", cpu_reset, 1'b1);
    check("ar_test_sel", test_sel, 0);
    check("ar_pass", pass_count, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ar_start_ignored", busy, 1'b0);
    reset = 1'b1;
    tick();
    check("ar_idle_after", busy, 1'b0);
    check("ar_no_load", load_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
